// File: rtl/sram_load_pkg.sv
// sram_load_pkg: shared types and constants for the SRAM load path.
//   ldState_e : load-unit FSM states (IDLE, READ, DRAIN, RESP)
//   ldMode_e  : extension mode carried on req_mode (AUTO, SIGNED, ZERO, RSVD)
//   SIZE_HALF / SIZE_FULL : encodings of req_size
package sram_load_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } ldState_e;

  typedef enum logic [1:0] {
    AUTO   = 2'b00,
    SIGNED = 2'b01,
    ZERO   = 2'b10,
    RSVD   = 2'b11
  } ldMode_e;

  localparam logic SIZE_HALF = 1'b0;
  localparam logic SIZE_FULL = 1'b1;

endpackage

// File: rtl/sram_load_unit_extender.sv
// mem_extender: widens one MEM_W SRAM word to DATA_W, either by replicating
// the word's top bit (signExt=1) or by zero-filling (signExt=0).
// Ports:
//   memData  in  MEM_W   raw SRAM word
//   signExt  in  1       1 = sign-extend, 0 = zero-extend
//   extData  out DATA_W  extended word
module mem_extender #(
  parameter int MEM_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic [MEM_W-1:0]  memData,
  input  logic              signExt,
  output logic [DATA_W-1:0] extData
);

  if (DATA_W > MEM_W) begin : gExt
    assign extData = {{(DATA_W-MEM_W){signExt & memData[MEM_W-1]}}, memData};
  end else begin : gPass
    // Equal widths: nothing to fill.
    assign extData = memData[DATA_W-1:0];
  end

endmodule

// File: rtl/sram_load_unit.sv
// sram_load_unit: load path between the CPU memory stage and a narrow
// synchronous data SRAM. One request per handshake; a half load reads one
// SRAM word and extends it, a full load reads DATA_W/MEM_W consecutive words
// and packs them little-endian. Requests past the legal region or with the
// reserved mode return rsp_err=1 / rsp_data=0 without touching the SRAM.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   req_valid/req_ready           request handshake
//   req_addr, req_size, req_mode  first-beat word address, half/full, mode
//   sram_rd_en, sram_addr         registered SRAM read strobe and address
//   sram_rdata                    SRAM data, valid the cycle after a read
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_err             result and illegal-request flag
module sram_load_unit
  import sram_load_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int MEM_W      = 16,
  parameter int ADDR_W     = 11,
  parameter int SIGNED_END = 5,
  parameter int ZERO_END   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_size,
  input  logic [1:0]        req_mode,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [MEM_W-1:0]  sram_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int BEATS = DATA_W / MEM_W;
  localparam int BW    = $clog2(BEATS + 1);
  localparam int AW1   = ADDR_W + 1;

  if ((DATA_W % MEM_W) != 0 || DATA_W < MEM_W) begin : gChkWidth
    $error("sram_load_unit: DATA_W must be a positive multiple of MEM_W");
  end
  if (SIGNED_END < 0 || SIGNED_END > ZERO_END || ZERO_END > (1 << ADDR_W)) begin : gChkRegion
    $error("sram_load_unit: need 0 <= SIGNED_END <= ZERO_END <= 2**ADDR_W");
  end

  ldState_e          state;
  ldMode_e           modeQ;
  logic              sizeQ;
  logic [ADDR_W-1:0] baseAddr;
  logic [BW-1:0]     nBeatsQ, beat, capCnt;
  logic              rdPend;   // SRAM data for an issued beat is on sram_rdata
  logic [DATA_W-1:0] capReg, capNext, extData, result;
  logic [BW-1:0]     reqBeats;
  logic [AW1-1:0]    lastAddr;
  logic              reqIllegal, signSel, lastIssue;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // Last-beat address is formed one bit wider so a request running off the
  // top of the address space is caught instead of wrapping to a low address.
  always_comb begin
    reqBeats   = (req_size == SIZE_FULL) ? BW'(BEATS) : BW'(1);
    lastAddr   = {1'b0, req_addr} + AW1'(reqBeats) - AW1'(1);
    reqIllegal = (req_mode == RSVD) || (lastAddr >= AW1'(ZERO_END));
  end

  assign lastIssue = (beat == nBeatsQ - BW'(1));

  // Merge the beat currently on sram_rdata into its little-endian slot.
  always_comb begin
    capNext = capReg;
    capNext[int'(capCnt)*MEM_W +: MEM_W] = sram_rdata;
  end

  assign signSel = (modeQ == SIGNED) ||
                   (modeQ == AUTO && {1'b0, baseAddr} < AW1'(SIGNED_END));

  mem_extender #(.MEM_W(MEM_W), .DATA_W(DATA_W)) uExt (
    .memData (capNext[MEM_W-1:0]),
    .signExt (signSel),
    .extData (extData)
  );

  assign result = (sizeQ == SIZE_FULL) ? capNext : extData;

  // The first read is launched on the accept edge so each READ cycle shows
  // the read for its own beat; the final beat's data lands during DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      modeQ      <= AUTO;
      sizeQ      <= SIZE_HALF;
      baseAddr   <= '0;
      nBeatsQ    <= '0;
      beat       <= '0;
      capCnt     <= '0;
      rdPend     <= 1'b0;
      capReg     <= '0;
      sram_rd_en <= 1'b0;
      sram_addr  <= '0;
      rsp_data   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rdPend <= sram_rd_en;
      if (rdPend) begin
        capReg <= capNext;
        capCnt <= capCnt + BW'(1);
      end
      unique case (state)
        IDLE: if (req_valid) begin
          baseAddr <= req_addr;
          sizeQ    <= req_size;
          modeQ    <= ldMode_e'(req_mode);
          nBeatsQ  <= reqBeats;
          beat     <= '0;
          capCnt   <= '0;
          capReg   <= '0;
          if (reqIllegal) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
            state    <= RESP;
          end else begin
            rsp_err    <= 1'b0;
            sram_rd_en <= 1'b1;
            sram_addr  <= req_addr;
            state      <= READ;
          end
        end
        READ: begin
          if (lastIssue) begin
            sram_rd_en <= 1'b0;
            state      <= DRAIN;
          end else begin
            sram_addr <= baseAddr + ADDR_W'(beat + BW'(1));
            beat      <= beat + BW'(1);
          end
        end
        DRAIN: begin
          rsp_data <= result;
          state    <= RESP;
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_load_unit.sv
module tb_sram_load_unit;
  localparam int DATA_W     = 32;
  localparam int MEM_W      = 16;
  localparam int ADDR_W     = 11;
  localparam int SIGNED_END = 5;
  localparam int ZERO_END   = 9;
  localparam int BEATS      = DATA_W / MEM_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_size = 1'b0;
  logic [1:0]        req_mode = 2'b00;
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_addr;
  logic [MEM_W-1:0]  sram_rdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  int total = 0;
  int bad   = 0;

  sram_load_unit #(
    .DATA_W(DATA_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W),
    .SIGNED_END(SIGNED_END), .ZERO_END(ZERO_END)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_mode(req_mode),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM model; outside read-response cycles it drives noise.
  logic [MEM_W-1:0] mem [0:(1<<ADDR_W)-1];
  int rdLog[$];
  always @(posedge clk) begin
    if (sram_rd_en) begin
      sram_rdata <= mem[sram_addr];
      rdLog.push_back(int'(sram_addr));
    end else begin
      sram_rdata <= MEM_W'($urandom);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: load semantics from the region/mode rules, plain arithmetic.
  function automatic void refModel(input int addr, input bit size, input int mode,
                                   output logic [31:0] data, output bit err, output int lat);
    int nb;
    int v;
    bit sgn;
    nb   = size ? BEATS : 1;
    err  = (mode == 3) || (addr + nb - 1 >= ZERO_END);
    data = '0;
    if (!err) begin
      if (size) begin
        for (int k = 0; k < nb; k++) data |= 32'(mem[addr+k]) << (MEM_W*k);
      end else begin
        v   = int'(mem[addr]);
        sgn = (mode == 1) || (mode == 0 && addr < SIGNED_END);
        if (sgn && v >= (1 << (MEM_W-1))) v = v - (1 << MEM_W);
        data = 32'(v);
      end
    end
    lat = err ? 1 : 2 + nb;
  endfunction

  // Cycles counted with the accept edge as 1; gives up after 40.
  task automatic waitRsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic runTxn(input string nm, input int addr, input bit size, input bit [1:0] mode,
                        input logic [31:0] expData, input bit expErr, input int expLat);
    int lat;
    int nb;
    nb = expErr ? 0 : (size ? BEATS : 1);
    @(negedge clk);
    chk({nm, " req_ready"}, 64'(req_ready), 64'(1));
    rdLog.delete();
    req_addr  = ADDR_W'(addr);
    req_size  = size;
    req_mode  = mode;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    waitRsp(lat);
    chk({nm, " latency"}, 64'(lat), 64'(expLat));
    chk({nm, " data"}, 64'(rsp_data), 64'(expData));
    chk({nm, " err"}, 64'(rsp_err), 64'(expErr));
    chk({nm, " nreads"}, 64'(rdLog.size()), 64'(nb));
    for (int k = 0; k < nb && k < rdLog.size(); k++)
      chk($sformatf("%s rdaddr%0d", nm, k), 64'(rdLog[k]), 64'(addr + k));
    @(posedge clk); #1;
    chk({nm, " retired"}, 64'(rsp_valid), 64'(0));
  endtask

  typedef struct {
    string       nm;
    int          addr;
    bit          size;
    bit [1:0]    mode;
    logic [15:0] m0, m1;
    logic [31:0] expData;
    bit          expErr;
    int          expLat;
  } vec_t;

  function automatic vec_t mkVec(input string nm, input int addr, input bit size, input bit [1:0] mode,
                                 input logic [15:0] m0, input logic [15:0] m1,
                                 input logic [31:0] ed, input bit ee, input int el);
    vec_t v;
    v.nm = nm; v.addr = addr; v.size = size; v.mode = mode; v.m0 = m0; v.m1 = m1;
    v.expData = ed; v.expErr = ee; v.expLat = el;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int lat;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;

    vecs.push_back(mkVec("auto_sgn_a3",  3, 0, 2'b00, 16'h8001, 16'h0000, 32'hFFFF8001, 0, 3));
    vecs.push_back(mkVec("auto_zero_a6", 6, 0, 2'b00, 16'h8001, 16'h0000, 32'h00008001, 0, 3));
    vecs.push_back(mkVec("zero_a2",      2, 0, 2'b10, 16'h8001, 16'h0000, 32'h00008001, 0, 3));
    vecs.push_back(mkVec("sgn_a7_pos",   7, 0, 2'b01, 16'h7FFF, 16'h0000, 32'h00007FFF, 0, 3));
    vecs.push_back(mkVec("sgn_a7_neg",   7, 0, 2'b01, 16'hF000, 16'h0000, 32'hFFFFF000, 0, 3));
    vecs.push_back(mkVec("auto_a4_edge", 4, 0, 2'b00, 16'h8000, 16'h0000, 32'hFFFF8000, 0, 3));
    vecs.push_back(mkVec("auto_a5_edge", 5, 0, 2'b00, 16'h8000, 16'h0000, 32'h00008000, 0, 3));
    vecs.push_back(mkVec("half_a8_ok",   8, 0, 2'b00, 16'hC3C3, 16'h0000, 32'h0000C3C3, 0, 3));
    vecs.push_back(mkVec("full_a4",      4, 1, 2'b00, 16'h1234, 16'hABCD, 32'hABCD1234, 0, 4));
    vecs.push_back(mkVec("full_a7_ok",   7, 1, 2'b01, 16'h8765, 16'hFEDC, 32'hFEDC8765, 0, 4));
    vecs.push_back(mkVec("ill_half_a9",  9, 0, 2'b00, 16'h1111, 16'h2222, 32'h00000000, 1, 1));
    vecs.push_back(mkVec("ill_full_a8",  8, 1, 2'b00, 16'h3333, 16'h4444, 32'h00000000, 1, 1));
    vecs.push_back(mkVec("ill_mode3_a0", 0, 0, 2'b11, 16'h5555, 16'h6666, 32'h00000000, 1, 1));

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset req_ready",  64'(req_ready),  64'(1));
    chk("reset sram_rd_en", 64'(sram_rd_en), 64'(0));
    chk("reset sram_addr",  64'(sram_addr),  64'(0));
    chk("reset rsp_valid",  64'(rsp_valid),  64'(0));
    chk("reset rsp_data",   64'(rsp_data),   64'(0));
    chk("reset rsp_err",    64'(rsp_err),    64'(0));

    // Directed table
    foreach (vecs[i]) begin
      mem[vecs[i].addr]   = vecs[i].m0;
      mem[vecs[i].addr+1] = vecs[i].m1;
      runTxn(vecs[i].nm, vecs[i].addr, vecs[i].size, vecs[i].mode,
             vecs[i].expData, vecs[i].expErr, vecs[i].expLat);
    end

    // Backpressure with a second request pending
    mem[3] = 16'h8001;
    mem[6] = 16'h1234;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_addr = 3; req_size = 1'b0; req_mode = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 6;                       // request B stays valid
    waitRsp(lat);
    chk("bp A latency", 64'(lat), 64'(3));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp hold%0d valid", c), 64'(rsp_valid), 64'(1));
      chk($sformatf("bp hold%0d data", c),  64'(rsp_data),  64'(32'hFFFF8001));
      chk($sformatf("bp hold%0d err", c),   64'(rsp_err),   64'(0));
      chk($sformatf("bp hold%0d ready", c), 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;                 // A retires here, B not yet taken
    chk("bp retire valid", 64'(rsp_valid),  64'(0));
    chk("bp retire ready", 64'(req_ready),  64'(1));
    chk("bp retire rd_en", 64'(sram_rd_en), 64'(0));
    @(posedge clk); #1;                 // B accepted here
    req_valid = 1'b0;
    chk("bp B accepted", 64'(req_ready),  64'(0));
    chk("bp B rd_en",    64'(sram_rd_en), 64'(1));
    chk("bp B addr",     64'(sram_addr),  64'(6));
    waitRsp(lat);
    chk("bp B latency", 64'(lat),      64'(3));
    chk("bp B data",    64'(rsp_data), 64'(32'h00001234));
    @(posedge clk); #1;

    // Reset during READ of a full load
    mem[4] = 16'hAAAA; mem[5] = 16'hBBBB;
    @(negedge clk);
    req_addr = 4; req_size = 1'b1; req_mode = 2'b00; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst pre rd_en", 64'(sram_rd_en), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst rd_en",     64'(sram_rd_en), 64'(0));
    chk("rst rsp_valid", 64'(rsp_valid),  64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst release ready", 64'(req_ready), 64'(1));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst no rsp%0d", c), 64'(rsp_valid), 64'(0));
    end
    mem[0] = 16'h8123;
    runTxn("rst next a0", 0, 0, 2'b00, 32'hFFFF8123, 0, 3);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      int a;
      bit s;
      bit [1:0] m;
      logic [31:0] ed;
      bit ee;
      int el;
      a = int'($urandom_range(0, 12));
      s = 1'($urandom_range(0, 1));
      m = 2'($urandom_range(0, 3));
      mem[a]   = MEM_W'($urandom);
      mem[a+1] = MEM_W'($urandom);
      refModel(a, s, int'(m), ed, ee, el);
      runTxn($sformatf("rnd%0d", i), a, s, m, ed, ee, el);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_load_unit.md
Name: sram_load_unit

Overview:
- Load-path unit between the CPU memory stage and the narrow data SRAM.
- Accepts one load request per handshake and issues one or more synchronous SRAM reads. Assembles the beats into a DATA_W result and sign- or zero-extends it according to the address region or an explicit mode.
- Returns the result with a valid/ready response.
- Replaces the combinational region-based extender with defined, parametrised, multi-beat behaviour.

Parameters:
- DATA_W, 32, result width; must be an integer multiple of MEM_W.
- MEM_W, 16, SRAM word width.
- ADDR_W, 11, SRAM address width.
- SIGNED_END, 5, addresses below this value are the signed region.
- ZERO_END, 9, addresses from SIGNED_END to ZERO_END-1 are the zero-extend region; addresses at or above this value are illegal. Must satisfy SIGNED_END <= ZERO_END <= 2**ADDR_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  ADDR_W  SRAM word address of first beat
- req_size  in  1  0 = half (1 beat), 1 = full (BEATS = DATA_W/MEM_W beats)
- req_mode  in  2  00 AUTO (by region), 01 SIGNED, 10 ZERO, 11 reserved
- sram_rd_en  out  1  SRAM read strobe
- sram_addr  out  ADDR_W  SRAM read address
- sram_rdata  in  MEM_W  SRAM read data, valid the cycle after sram_rd_en
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  DATA_W  assembled/extended load data
- rsp_err  out  1  request was illegal; rsp_data is 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset state: state IDLE. Outputs after reset: req_ready=1, sram_rd_en=0, sram_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0. Beat counter and capture register are 0.
- FSM states: IDLE, READ, DRAIN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr/size/mode.
  - Illegal request → RESP with rsp_err=1 and rsp_data=0; no SRAM access is made. A request is illegal if any of:
    - req_mode==11;
    - last beat address (addr+nbeats-1) >= ZERO_END, computed at ADDR_W+1 bits, so there is no wrap-around.
  - Legal request → READ with beat=0.
- READ:
  - Each cycle, drive sram_rd_en=1 and sram_addr=base+beat (registered outputs); beat increments.
  - After the last beat is issued → DRAIN.
  - sram_rdata from the previous cycle's issue is captured into bits [k*MEM_W +: MEM_W] (little-endian beat order).
- DRAIN: sram_rd_en=0; capture the final beat; form the result → RESP.
- Extension (half loads only):
  - SIGNED: replicate bit MEM_W-1 into the upper bits.
  - ZERO: zero-fill the upper bits.
  - AUTO: signed if addr < SIGNED_END, otherwise zero.
  - Full loads perform no extension and ignore the mode except for the reserved-mode error.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready → IDLE.
  - req_ready=0 in every state except IDLE. No request is accepted in the same cycle a response retires.
- Latency, counted from the accept edge:
  - illegal request: rsp_valid after 1 cycle;
  - half load: rsp_valid after 3 cycles;
  - full load: rsp_valid after 2+BEATS cycles.
- Reset asserted mid-operation: immediate return to IDLE; sram_rd_en drops asynchronously; any in-flight response is discarded.
- sram_rdata is ignored in every cycle not following a read issue.

Decomposition:
- Package sram_load_pkg holds:
  - the state enum (IDLE, READ, DRAIN, RESP);
  - the mode enum (AUTO, SIGNED, ZERO, RSVD);
  - size constants (SIZE_HALF, SIZE_FULL).
- One combinational sub-module, mem_extender: MEM_W→DATA_W with a signed select, parametrised on both widths.
- Elaboration-time assertions check the parameter constraints.

Test Plan (DATA_W=32, MEM_W=16, SIGNED_END=5, ZERO_END=9):
1. Half AUTO addr 3, SRAM[3]=0x8001 → a single read at addr 3; rsp_data=0xFFFF8001, rsp_err=0, rsp_valid 3 cycles after accept. Half AUTO addr 6, SRAM[6]=0x8001 → 0x00008001.
2. Mode override: half ZERO addr 2, SRAM[2]=0x8001 → 0x00008001. Half SIGNED addr 7, SRAM[7]=0x7FFF → 0x00007FFF. Half SIGNED addr 7, SRAM[7]=0xF000 → 0xFFFFF000.
3. Full load addr 4, SRAM[4]=0x1234, SRAM[5]=0xABCD → reads at addr 4 then addr 5 on consecutive cycles; rsp_data=0xABCD1234 after 4 cycles.
4. Illegal requests: half addr 9, full addr 8, and mode 11 at addr 0 → each gives rsp_err=1, rsp_data=0, sram_rd_en never asserted, rsp_valid 1 cycle after accept.
5. Backpressure: rsp_ready held low 5 cycles with a second req_valid pending → rsp_data/rsp_err stable, req_ready=0. The second request is accepted only in the cycle after the response retires.
6. rst_n pulsed low during READ of a full load → sram_rd_en=0 and rsp_valid=0 immediately; req_ready=1 after release. The next half load at addr 0 completes with correct data.
